ipg_slot_scheduler: RTL and testbench



---
 rtl/phy_10g_pkg.sv | 65 ++++++
 rtl/ipg_slot_scheduler_if.sv | 21 ++
 rtl/ipg_sync_fifo.sv | 52 +++++
 rtl/ipg_slot_scheduler.sv | 132 +++++++++++++
 tb/tb_ipg_slot_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/phy_10g_pkg.sv
// phy_10g_pkg: shared 10G PHY TX-path constants, scheduler state type
// and a 64b/66b block classifier for the IPG slot scheduler.
package phy_10g_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [7:0] BLOCK_TYPE_IDLE = 8'h1e;
  localparam logic [7:0] BLOCK_TYPE_S0   = 8'h78;
  localparam logic [7:0] BLOCK_TYPE_S4   = 8'h33;
  localparam logic [7:0] BLOCK_TYPE_O0S4 = 8'h66;
  localparam logic [7:0] BLOCK_TYPE_T0   = 8'h87;
  localparam logic [7:0] BLOCK_TYPE_T1   = 8'h99;
  localparam logic [7:0] BLOCK_TYPE_T2   = 8'haa;
  localparam logic [7:0] BLOCK_TYPE_T3   = 8'hb4;
  localparam logic [7:0] BLOCK_TYPE_T4   = 8'hcc;
  localparam logic [7:0] BLOCK_TYPE_T5   = 8'hd2;
  localparam logic [7:0] BLOCK_TYPE_T6   = 8'he1;
  localparam logic [7:0] BLOCK_TYPE_T7   = 8'hff;

  localparam logic [63:0] IDLE_BLOCK = 64'h1e;

  typedef enum logic [1:0] {
    OPEN,
    FRAME,
    GUARD
  } sched_state_t;

  typedef enum logic [2:0] {
    BLK_IDLE,
    BLK_START,
    BLK_TERM,
    BLK_DATA,
    BLK_OTHER
  } blk_class_t;

  // An idle block must be all-idle: type 0x1e with zero control chars.
  function automatic blk_class_t classify(
    input logic [1:0]  hdr,
    input logic [63:0] data
  );
    blk_class_t c;
    c = BLK_OTHER;
    if (hdr == SYNC_DATA) begin
      c = BLK_DATA;
    end else if (hdr == SYNC_CTRL) begin
      if (data == IDLE_BLOCK) begin
        c = BLK_IDLE;
      end else begin
        case (data[7:0])
          BLOCK_TYPE_S0,
          BLOCK_TYPE_S4,
          BLOCK_TYPE_O0S4: c = BLK_START;
          BLOCK_TYPE_T0, BLOCK_TYPE_T1,
          BLOCK_TYPE_T2, BLOCK_TYPE_T3,
          BLOCK_TYPE_T4, BLOCK_TYPE_T5,
          BLOCK_TYPE_T6, BLOCK_TYPE_T7: c = BLK_TERM;
          default: c = BLK_OTHER;
        endcase
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/ipg_slot_scheduler_if.sv
// ipg_slot_scheduler_if: valid/ready stream carrying IPG payload blocks.
// tdata/tvalid from requester (master), tready back from scheduler (slave).
interface ipg_slot_scheduler_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/ipg_sync_fifo.sv
// ipg_sync_fifo: single-clock FIFO, async active-high reset.
// Ports: push/push_data in, pop in, head/full/empty/level out.
module ipg_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/ipg_slot_scheduler.sv
// ipg_slot_scheduler: swaps queued IPG blocks into out-of-frame idle slots.
// Ports: clk/rst; enc_tx_* in; s_ipg stream in; out_tx_*, ipg_inserted,
// fifo_level, insert_count out. All outputs registered, 1-cycle latency.
module ipg_slot_scheduler
  import phy_10g_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int HDR_WIDTH    = 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int GUARD_BLOCKS = 2,
  parameter int MAX_BURST    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       enc_tx_data,
  input  logic [HDR_WIDTH-1:0]        enc_tx_hdr,
  ipg_slot_scheduler_if.slave         s_ipg,
  output logic [DATA_WIDTH-1:0]       out_tx_data,
  output logic [HDR_WIDTH-1:0]        out_tx_hdr,
  output logic                        ipg_inserted,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [31:0]                 insert_count
);
  localparam int GW = $clog2(GUARD_BLOCKS + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  blk_class_t      blk;
  sched_state_t    state_q;
  sched_state_t    state_d;
  logic [GW-1:0]   guard_q;
  logic [GW-1:0]   guard_d;
  logic [GW-1:0]   guard_inc;
  logic [BW-1:0]   burst_q;
  logic [BW-1:0]   burst_d;
  logic            insert;
  logic            push;
  logic            fifo_full;
  logic            fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  assign blk       = classify(enc_tx_hdr, enc_tx_data);
  assign guard_inc = guard_q + 1'b1;

  // Ready follows the registered level only; a full queue frees
  // a slot one cycle after the pop, never in the same cycle.
  assign s_ipg.tready = ~fifo_full;
  assign push         = s_ipg.tvalid & ~fifo_full;

  ipg_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (s_ipg.tdata),
    .pop       (insert),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    burst_d = burst_q;
    insert  = (state_q == OPEN) &&
              (blk == BLK_IDLE) &&
              !fifo_empty &&
              (burst_q < BW'(MAX_BURST));
    unique case (state_q)
      OPEN: begin
        // Only an idle actually passed on clears the burst run.
        if (insert) begin
          burst_d = burst_q + 1'b1;
        end else if (blk == BLK_IDLE) begin
          burst_d = '0;
        end
        if (blk == BLK_START) begin
          state_d = FRAME;
        end else if (blk == BLK_OTHER) begin
          state_d = GUARD;
          guard_d = '0;
        end
      end
      FRAME: begin
        if (blk == BLK_TERM || blk == BLK_OTHER) begin
          state_d = GUARD;
          guard_d = '0;
        end
      end
      GUARD: begin
        unique case (1'b1)
          blk == BLK_IDLE: begin
            guard_d = guard_inc;
            if (guard_inc == GW'(GUARD_BLOCKS)) begin
              state_d = OPEN;
              guard_d = '0;
              burst_d = '0;
            end
          end
          blk == BLK_START: state_d = FRAME;
          blk == BLK_DATA,
          blk == BLK_OTHER: guard_d = '0;
          default: ;
        endcase
      end
      default: state_d = GUARD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= GUARD;
      guard_q      <= '0;
      burst_q      <= '0;
      out_tx_data  <= DATA_WIDTH'(IDLE_BLOCK);
      out_tx_hdr   <= HDR_WIDTH'(SYNC_CTRL);
      ipg_inserted <= 1'b0;
      insert_count <= '0;
    end else begin
      state_q      <= state_d;
      guard_q      <= guard_d;
      burst_q      <= burst_d;
      out_tx_data  <= insert ? fifo_head : enc_tx_data;
      out_tx_hdr   <= insert ? HDR_WIDTH'(SYNC_CTRL) : enc_tx_hdr;
      ipg_inserted <= insert;
      if (insert) insert_count <= insert_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_ipg_slot_scheduler.sv
// tb_ipg_slot_scheduler: directed + random bench for ipg_slot_scheduler,
// checked against a queue-based reference model of the scheduling rules.
module tb_ipg_slot_scheduler;
  localparam int DEPTH = 8;
  localparam int GUARD = 2;
  localparam int MAXB  = 4;
  localparam logic [63:0] IDLE = 64'h1e;
  localparam int C_IDLE = 0, C_START = 1, C_TERM = 2, C_DATA = 3, C_OTHER = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] enc_data;
  logic [1:0]  enc_hdr;
  logic [63:0] out_data;
  logic [1:0]  out_hdr;
  logic        ins;
  logic [3:0]  level;
  logic [31:0] count;

  ipg_slot_scheduler_if #(.DATA_WIDTH(64)) ipg();

  ipg_slot_scheduler #(
    .DATA_WIDTH(64), .HDR_WIDTH(2), .FIFO_DEPTH(DEPTH),
    .GUARD_BLOCKS(GUARD), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .rst(rst),
    .enc_tx_data(enc_data), .enc_tx_hdr(enc_hdr),
    .s_ipg(ipg),
    .out_tx_data(out_data), .out_tx_hdr(out_hdr),
    .ipg_inserted(ins), .fifo_level(level), .insert_count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef enum {M_OPEN, M_FRAME, M_GUARD} mstate_t;
  mstate_t     m_state;
  int          m_gseen;
  int          m_burst;
  logic [31:0] m_count;
  logic [63:0] m_q [$];
  logic [63:0] exp_data;
  logic [1:0]  exp_hdr;
  bit          exp_ins;
  bit          exp_rdy;
  logic        obs_rdy;
  bit          last_push;
  logic [63:0] push_seq;

  logic [7:0] st_types [3] = '{8'h78, 8'h33, 8'h66};
  logic [7:0] tm_types [8] = '{8'h87, 8'h99, 8'haa, 8'hb4,
                               8'hcc, 8'hd2, 8'he1, 8'hff};

  function automatic int blk_class(logic [1:0] h, logic [63:0] d);
    if (h == 2'b01) return C_DATA;
    if (h != 2'b10) return C_OTHER;
    if (d == IDLE) return C_IDLE;
    if (d[7:0] inside {8'h78, 8'h33, 8'h66}) return C_START;
    if (d[7:0] inside {8'h87, 8'h99, 8'haa, 8'hb4,
                       8'hcc, 8'hd2, 8'he1, 8'hff}) return C_TERM;
    return C_OTHER;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_state  = M_GUARD;
    m_gseen  = 0;
    m_burst  = 0;
    m_count  = '0;
    exp_data = IDLE;
    exp_hdr  = 2'b10;
    exp_ins  = 1'b0;
  endtask

  // Apply one block (and optional push), advance one clock, update model.
  task automatic step(input logic [1:0] h, input logic [63:0] d,
                      input bit v, input logic [63:0] td);
    int c;
    bit do_ins;
    bit do_push;
    enc_hdr    = h;
    enc_data   = d;
    ipg.tvalid = v;
    ipg.tdata  = td;
    exp_rdy = (m_q.size() != DEPTH);
    obs_rdy = ipg.tready;
    do_push = v && exp_rdy;
    c = blk_class(h, d);
    do_ins = (m_state == M_OPEN) && (c == C_IDLE) &&
             (m_q.size() > 0) && (m_burst < MAXB);
    @(posedge clk);
    exp_ins  = do_ins;
    exp_hdr  = do_ins ? 2'b10 : h;
    exp_data = do_ins ? m_q[0] : d;
    if (do_ins) begin
      void'(m_q.pop_front());
      m_burst++;
      m_count++;
    end else if (m_state == M_OPEN && c == C_IDLE) begin
      m_burst = 0;
    end
    if (do_push) m_q.push_back(td);
    last_push = do_push;
    case (m_state)
      M_OPEN: begin
        if (c == C_START) m_state = M_FRAME;
        else if (c == C_OTHER) begin m_state = M_GUARD; m_gseen = 0; end
      end
      M_FRAME: begin
        if (c == C_TERM || c == C_OTHER) begin m_state = M_GUARD; m_gseen = 0; end
      end
      default: begin
        if (c == C_IDLE) begin
          m_gseen++;
          if (m_gseen == GUARD) begin m_state = M_OPEN; m_burst = 0; m_gseen = 0; end
        end else if (c == C_START) m_state = M_FRAME;
        else if (c == C_DATA || c == C_OTHER) m_gseen = 0;
      end
    endcase
    #1;
  endtask

  task automatic test_reset();
    ipg.tvalid = 1'b0;
    ipg.tdata  = '0;
    enc_hdr    = 2'b10;
    enc_data   = IDLE;
    push_seq   = 64'h1000;
    m_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_data !== 64'h1e) begin errors++; $display("FAIL reset_data: got %h want %h", out_data, 64'h1e); end
    checks++; if (out_hdr !== 2'b10) begin errors++; $display("FAIL reset_hdr: got %b want 10", out_hdr); end
    checks++; if (ins !== 1'b0) begin errors++; $display("FAIL reset_ins: got %b want 0", ins); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (ipg.tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b want 1", ipg.tready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_idle_pass();
    for (int i = 0; i < 10; i++) begin
      step(2'b10, IDLE, 1'b0, '0);
      checks++; if (out_data !== IDLE || out_data !== exp_data) begin errors++; $display("FAIL idle_data[%0d]: got %h want %h", i, out_data, exp_data); end
      checks++; if (out_hdr !== exp_hdr) begin errors++; $display("FAIL idle_hdr[%0d]: got %b want %b", i, out_hdr, exp_hdr); end
      checks++; if (ins !== 1'b0) begin errors++; $display("FAIL idle_ins[%0d]: got %b want 0", i, ins); end
    end
  endtask

  task automatic test_insert();
    logic [63:0] pd [4];
    bit          pv [4];
    logic [3:0]  pat;
    pd = '{64'hAAAA_0001, 64'hBBBB_0002, 64'h0, 64'h0};
    pv = '{1'b1, 1'b1, 1'b0, 1'b0};
    pat = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      step(2'b10, IDLE, pv[i], pd[i]);
      checks++; if (out_data !== exp_data) begin errors++; $display("FAIL ins_data[%0d]: got %h want %h", i, out_data, exp_data); end
      checks++; if (out_hdr !== 2'b10) begin errors++; $display("FAIL ins_hdr[%0d]: got %b want 10", i, out_hdr); end
      checks++; if (ins !== pat[i] || ins !== exp_ins) begin errors++; $display("FAIL ins_flag[%0d]: got %b want %b", i, ins, pat[i]); end
    end
    checks++; if (count !== 32'd2) begin errors++; $display("FAIL ins_count: got %0d want 2", count); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL ins_level: got %0d want 0", level); end
  endtask

  task automatic test_frame();
    logic [1:0]  h;
    logic [63:0] d;
    for (int i = 0; i < 11; i++) begin
      if (i == 0) begin h = 2'b10; d = {56'h11223344556677, 8'h78}; end
      else if (i < 6) begin h = 2'b01; d = {$urandom(), $urandom()}; end
      else if (i == 6) begin h = 2'b10; d = {56'h0, 8'h87}; end
      else begin h = 2'b10; d = IDLE; end
      step(h, d, i < 3, push_seq);
      if (last_push) push_seq++;
      checks++; if (out_data !== exp_data) begin errors++; $display("FAIL frame_data[%0d]: got %h want %h", i, out_data, exp_data); end
      checks++; if (out_hdr !== exp_hdr) begin errors++; $display("FAIL frame_hdr[%0d]: got %b want %b", i, out_hdr, exp_hdr); end
      checks++; if (ins !== (i >= 9)) begin errors++; $display("FAIL frame_ins[%0d]: got %b want %b", i, ins, i >= 9); end
    end
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL frame_level: got %0d want 1", level); end
    checks++; if (count !== 32'd4) begin errors++; $display("FAIL frame_count: got %0d want 4", count); end
  endtask

  task automatic test_burst();
    logic [7:0] pat;
    pat = 8'b0110_1111;
    step(2'b10, {56'h0, 8'h33}, 1'b1, push_seq);
    if (last_push) push_seq++;
    for (int i = 0; i < 4; i++) begin
      step(2'b01, {$urandom(), $urandom()}, 1'b1, push_seq);
      if (last_push) push_seq++;
    end
    step(2'b10, {56'h0, 8'hcc}, 1'b0, '0);
    checks++; if (level !== 4'd6) begin errors++; $display("FAIL burst_setup_level: got %0d want 6", level); end
    step(2'b10, IDLE, 1'b0, '0);
    step(2'b10, IDLE, 1'b0, '0);
    for (int i = 0; i < 8; i++) begin
      step(2'b10, IDLE, 1'b0, '0);
      checks++; if (out_data !== exp_data) begin errors++; $display("FAIL burst_data[%0d]: got %h want %h", i, out_data, exp_data); end
      checks++; if (ins !== pat[i] || ins !== exp_ins) begin errors++; $display("FAIL burst_ins[%0d]: got %b want %b", i, ins, pat[i]); end
    end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL burst_level: got %0d want 0", level); end
  endtask

  task automatic test_full();
    step(2'b10, {56'h0, 8'h78}, 1'b1, push_seq);
    if (last_push) push_seq++;
    for (int i = 0; i < 9; i++) begin
      step(2'b01, {$urandom(), $urandom()}, 1'b1, push_seq);
      if (last_push) push_seq++;
    end
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_level: got %0d want 8", level); end
    checks++; if (ipg.tready !== 1'b0) begin errors++; $display("FAIL full_tready: got %b want 0", ipg.tready); end
    step(2'b10, {56'h0, 8'hff}, 1'b1, push_seq);
    step(2'b10, IDLE, 1'b1, push_seq);
    step(2'b10, IDLE, 1'b1, push_seq);
    for (int i = 0; i < 6; i++) begin
      step(2'b10, IDLE, 1'b1, push_seq);
      if (last_push) push_seq++;
      checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL full_rdy[%0d]: got %b want %b", i, obs_rdy, exp_rdy); end
      checks++; if (out_data !== exp_data) begin errors++; $display("FAIL full_data[%0d]: got %h want %h", i, out_data, exp_data); end
      checks++; if (ins !== exp_ins) begin errors++; $display("FAIL full_ins[%0d]: got %b want %b", i, ins, exp_ins); end
      checks++; if (level > 4'd8 || level !== 4'(m_q.size())) begin errors++; $display("FAIL full_lvl[%0d]: got %0d want %0d", i, level, m_q.size()); end
      if (i == 0) begin
        checks++; if (level !== 4'd7) begin errors++; $display("FAIL full_no_bypass: got %0d want 7", level); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (m_q.size() != 3 && n < 40) begin
      step(2'b10, IDLE, 1'b0, '0);
      checks++; if (out_data !== exp_data) begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", n, out_data, exp_data); end
      n++;
    end
    checks++; if (level !== 4'd3) begin errors++; $display("FAIL rmid_setup_level: got %0d want 3", level); end
    #3 rst = 1'b1;
    #1;
    checks++; if (out_data !== 64'h1e) begin errors++; $display("FAIL rmid_data: got %h want %h", out_data, 64'h1e); end
    checks++; if (out_hdr !== 2'b10) begin errors++; $display("FAIL rmid_hdr: got %b want 10", out_hdr); end
    checks++; if (ins !== 1'b0) begin errors++; $display("FAIL rmid_ins: got %b want 0", ins); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL rmid_level: got %0d want 0", level); end
    checks++; if (count !== 32'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", count); end
    m_reset();
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(2'b10, IDLE, i < 2, push_seq);
      if (last_push) push_seq++;
      checks++; if (out_data !== exp_data) begin errors++; $display("FAIL rmid_post_data[%0d]: got %h want %h", i, out_data, exp_data); end
      checks++; if (ins !== (i >= 2)) begin errors++; $display("FAIL rmid_post_ins[%0d]: got %b want %b", i, ins, i >= 2); end
    end
    checks++; if (count !== 32'd2) begin errors++; $display("FAIL rmid_post_count: got %0d want 2", count); end
  endtask

  task automatic rand_block(output logic [1:0] h, output logic [63:0] d);
    int r;
    r = $urandom_range(99);
    d = {$urandom(), $urandom()};
    h = 2'b10;
    if (r < 45) d = IDLE;
    else if (r < 53) d[7:0] = st_types[$urandom_range(2)];
    else if (r < 61) d[7:0] = tm_types[$urandom_range(7)];
    else if (r < 85) h = 2'b01;
    else begin
      case (r % 4)
        0: h = 2'b00;
        1: h = 2'b11;
        2: d[7:0] = 8'h4b;
        default: d[7:0] = 8'h1e;
      endcase
    end
  endtask

  task automatic test_random();
    logic [1:0]  h;
    logic [63:0] d;
    int          vprob;
    vprob = 50;
    for (int i = 0; i < 2000; i++) begin
      if (i % 250 == 0) begin
        case ((i / 250) % 3)
          0: vprob = 15;
          1: vprob = 95;
          default: vprob = 50;
        endcase
      end
      rand_block(h, d);
      step(h, d, $urandom_range(99) < vprob, push_seq);
      if (last_push) push_seq++;
      checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL rand_rdy[%0d]: got %b want %b", i, obs_rdy, exp_rdy); end
      checks++; if (out_data !== exp_data) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, out_data, exp_data); end
      checks++; if (out_hdr !== exp_hdr) begin errors++; $display("FAIL rand_hdr[%0d]: got %b want %b", i, out_hdr, exp_hdr); end
      checks++; if (ins !== exp_ins) begin errors++; $display("FAIL rand_ins[%0d]: got %b want %b", i, ins, exp_ins); end
      checks++; if (level !== 4'(m_q.size())) begin errors++; $display("FAIL rand_level[%0d]: got %0d want %0d", i, level, m_q.size()); end
      checks++; if (count !== m_count) begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, count, m_count); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_pass();
    test_insert();
    test_frame();
    test_burst();
    test_full();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
